tz_scan_sched: RTL and testbench

Shared, iterative trailing-zero locator with a round-robin front end. NREQ requesters each present a DW-bit word. The block grants one requester at a time and runs a one-bit-per-cycle shift scan. It returns the index of the lowest set bit, or ZERO_LOC for an all-zero word. It sits between several producer blocks and a single scan datapath, so the datapath is time-shared rather than replicated.

---
 rtl/tz_scan_pkg.sv | 15 +
 rtl/tz_scan_sched_if.sv | 31 +++
 rtl/tz_scan_sched_rr_arbiter.sv | 33 +++
 rtl/tz_scan_sched.sv | 101 ++++++++++
 tb/tb_tz_scan_sched.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/tz_scan_pkg.sv
// Shared types and default sizing for the trailing-zero scan scheduler.
package tz_scan_pkg;

    localparam int unsigned DEF_NREQ     = 4;
    localparam int unsigned DEF_DW       = 8;
    localparam int unsigned DEF_LW       = 6;
    localparam int unsigned DEF_ZERO_LOC = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/tz_scan_sched_if.sv
// Requester/consumer bundle for the shared trailing-zero scanner.
interface tz_scan_sched_if
    import tz_scan_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned DW   = DEF_DW,
    parameter int unsigned LW   = DEF_LW,
    parameter int unsigned IW   = $clog2(NREQ)
);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IW-1:0]      rsp_id;
    logic [LW-1:0]      rsp_loc;
    logic [DW-1:0]      rsp_data;
    logic               busy;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_loc, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_loc, rsp_data, busy
    );

endinterface

// File: rtl/tz_scan_sched_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after rr_ptr, cyclically.
module rr_arbiter #(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx,
    output logic            any_req
);

    assign any_req = |req;

    // Walk offsets 0..NREQ-1 from the pointer and take the first hit.
    always_comb begin
        logic          found;
        logic [IW-1:0] idx;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = IW'((32'(rr_ptr) + i) % NREQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                gnt[idx]   = 1'b1;
                gnt_idx    = idx;
            end
        end
    end

endmodule

// File: rtl/tz_scan_sched.sv
// Time-shared trailing-zero locator: round-robin grant, then one-bit-per-cycle shift scan.
module tz_scan_sched
    import tz_scan_pkg::*;
#(
    parameter  int unsigned NREQ     = DEF_NREQ,
    parameter  int unsigned DW       = DEF_DW,
    parameter  int unsigned LW       = DEF_LW,
    parameter  int unsigned ZERO_LOC = DEF_ZERO_LOC,
    localparam int unsigned IW       = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             reset,
    tz_scan_sched_if.slave   bus
);

    state_e          state_q, state_d;
    logic [DW-1:0]   shreg_q, shreg_d;
    logic [LW-1:0]   loc_q,   loc_d;
    logic [IW-1:0]   id_q,    id_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;

    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            any_req;
    logic [DW-1:0]   word_sel;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (bus.req_valid),
        .rr_ptr  (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_req (any_req)
    );

    assign word_sel = bus.req_data[int'(gnt_idx) * DW +: DW];

    // Next-state: accept in IDLE, shift until bit0 set in SCAN, hold result in RESP.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        loc_d    = loc_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    shreg_d = word_sel;
                    id_d    = gnt_idx;
                    if (word_sel == '0) begin
                        loc_d   = LW'(ZERO_LOC);
                        state_d = RESP;
                    end else begin
                        loc_d   = '0;
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                if (shreg_q[0]) begin
                    state_d = RESP;
                end else begin
                    shreg_d = shreg_q >> 1;
                    loc_d   = loc_q + LW'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rr_ptr_d = IW'((32'(id_q) + 32'd1) % NREQ);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            loc_q    <= '0;
            id_q     <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            loc_q    <= loc_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Grant strobe depends only on registered state, reset and req_valid.
    assign bus.req_ready = (state_q == IDLE && !reset) ? gnt : '0;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.busy      = (state_q != IDLE);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_loc   = loc_q;
    assign bus.rsp_data  = shreg_q;

endmodule

// File: tb/tb_tz_scan_sched.sv
// Bench for tz_scan_sched: directed table, corner sequences and randomized traffic vs a model.
module tb_tz_scan_sched;

    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 8;
    localparam int unsigned LW   = 6;
    localparam int unsigned ZL   = 32;

    logic clk;
    logic reset;

    tz_scan_sched_if #(.NREQ(NREQ), .DW(DW), .LW(LW)) bus ();

    tz_scan_sched #(.NREQ(NREQ), .DW(DW), .LW(LW), .ZERO_LOC(ZL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int mptr    = 0;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        int          stall;
        int          e_id;
        int          e_loc;
        logic [7:0]  e_data;
        int          e_lat;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Round-robin reference: first valid index at or after the pointer, cyclically.
    function automatic int model_grant(input logic [3:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (ptr + k) % NREQ;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    // One full transaction from IDLE: grant, scan, optional stall, handshake.
    task automatic do_txn(input string nm, input logic [3:0] v, input logic [31:0] d,
                          input int stall, input int e_id, input int e_loc,
                          input logic [7:0] e_data, input int e_lat);
        int lat;
        bit bad;
        logic [1:0] s_id;
        logic [5:0] s_loc;
        logic [7:0] s_data;
        bus.req_valid = v;
        bus.req_data  = d;
        bus.rsp_ready = 1'b0;
        #1;
        check({nm, ".grant"}, 64'(bus.req_ready), 64'(4'b0001 << e_id));
        check({nm, ".idle_busy"}, 64'(bus.busy), 64'd0);
        step();
        bus.req_data = $urandom;
        lat = 1;
        bad = 1'b0;
        while (!bus.rsp_valid && lat < 40) begin
            if (bus.req_ready != 4'b0) bad = 1'b1;
            step();
            lat++;
        end
        check({nm, ".ready_quiet_scan"}, 64'(bad), 64'd0);
        check({nm, ".latency"}, 64'(lat), 64'(e_lat));
        check({nm, ".rsp_id"}, 64'(bus.rsp_id), 64'(e_id));
        check({nm, ".rsp_loc"}, 64'(bus.rsp_loc), 64'(e_loc));
        check({nm, ".rsp_data"}, 64'(bus.rsp_data), 64'(e_data));
        s_id = bus.rsp_id; s_loc = bus.rsp_loc; s_data = bus.rsp_data;
        bad = 1'b0;
        for (int s = 0; s < stall; s++) begin
            step();
            if (!bus.rsp_valid || bus.rsp_id != s_id || bus.rsp_loc != s_loc ||
                bus.rsp_data != s_data || bus.req_ready != 4'b0) bad = 1'b1;
        end
        if (stall > 0) check({nm, ".stall_stable"}, 64'(bad), 64'd0);
        bus.rsp_ready = 1'b1;
        #1;
        check({nm, ".ready_in_resp"}, 64'(bus.req_ready), 64'd0);
        step();
        bus.rsp_ready = 1'b0;
        check({nm, ".after_hs_valid"}, 64'(bus.rsp_valid), 64'd0);
        mptr = (e_id + 1) % NREQ;
    endtask

    vec_t tbl[10];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // word3=10, word2=20, word1=40, word0=01 for the all-valid rounds
        tbl[0] = '{4'b0001, 32'h0000_0003, 0, 0, 0,  8'h03, 2};
        tbl[1] = '{4'b0010, 32'h0000_0400, 0, 1, 2,  8'h01, 4};
        tbl[2] = '{4'b0010, 32'h0000_8000, 0, 1, 7,  8'h01, 9};
        tbl[3] = '{4'b0100, 32'h0000_0000, 0, 2, 32, 8'h00, 1};
        tbl[4] = '{4'b1111, 32'h1020_4001, 5, 3, 4,  8'h01, 6};
        tbl[5] = '{4'b1111, 32'h1020_4001, 0, 0, 0,  8'h01, 2};
        tbl[6] = '{4'b1111, 32'h1020_4001, 1, 1, 6,  8'h01, 8};
        tbl[7] = '{4'b1111, 32'h1020_4001, 0, 2, 5,  8'h01, 7};
        tbl[8] = '{4'b1111, 32'h1020_4001, 2, 3, 4,  8'h01, 6};
        tbl[9] = '{4'b1111, 32'h1020_4001, 0, 0, 0,  8'h01, 2};

        reset = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_data  = 32'h0;
        bus.rsp_ready = 1'b0;
        step(); step(); step();
        check("rst.req_ready", 64'(bus.req_ready), 64'd0);
        check("rst.rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst.busy", 64'(bus.busy), 64'd0);
        check("rst.rsp_id", 64'(bus.rsp_id), 64'd0);
        check("rst.rsp_loc", 64'(bus.rsp_loc), 64'd0);
        check("rst.rsp_data", 64'(bus.rsp_data), 64'd0);
        reset = 1'b0;
        bus.req_valid = 4'b0000;
        step();
        bus.req_valid = 4'b1111;
        #1;
        check("rst.ptr_zero", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 4'b0000;
        step();
        mptr = 0;

        for (int i = 0; i < 10; i++) begin
            do_txn($sformatf("tbl%0d", i), tbl[i].valid, tbl[i].data, tbl[i].stall,
                   tbl[i].e_id, tbl[i].e_loc, tbl[i].e_data, tbl[i].e_lat);
        end

        // Requester drops valid before acceptance: grant recomputes.
        bus.req_valid = 4'b0110;
        bus.req_data  = 32'h0000_0200;
        #1;
        check("drop.grant_a", 64'(bus.req_ready), 64'b0010);
        bus.req_valid = 4'b0100;
        #1;
        check("drop.grant_b", 64'(bus.req_ready), 64'b0100);
        do_txn("drop", 4'b0100, 32'h0002_0000, 0, 2, 1, 8'h01, 3);

        // Reset on the 3rd scan cycle abandons the transaction.
        bus.req_valid = 4'b0010;
        bus.req_data  = 32'h0000_8000;
        step();
        step();
        step();
        check("abort.busy_scan", 64'(bus.busy), 64'd1);
        check("abort.valid_scan", 64'(bus.rsp_valid), 64'd0);
        reset = 1'b1;
        bus.req_valid = 4'b1111;
        step();
        check("abort.busy", 64'(bus.busy), 64'd0);
        check("abort.rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("abort.rsp_loc", 64'(bus.rsp_loc), 64'd0);
        check("abort.rsp_data", 64'(bus.rsp_data), 64'd0);
        check("abort.rsp_id", 64'(bus.rsp_id), 64'd0);
        check("abort.req_ready", 64'(bus.req_ready), 64'd0);
        reset = 1'b0;
        #1;
        check("abort.ptr_zero", 64'(bus.req_ready), 64'd1);
        mptr = 0;
        do_txn("abort_req3", 4'b1000, 32'h0800_0000, 0, 3, 3, 8'h01, 5);

        // Randomized traffic against the reference model.
        for (int r = 0; r < 150; r++) begin
            logic [3:0]  v;
            logic [31:0] d;
            logic [7:0]  w;
            int g, k, lat;
            v = 4'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) begin
                case ($urandom_range(0, 3))
                    0:       d[i*8 +: 8] = 8'h00;
                    1:       d[i*8 +: 8] = 8'h01 << $urandom_range(0, 7);
                    default: d[i*8 +: 8] = 8'($urandom);
                endcase
            end
            g = model_grant(v, mptr);
            w = d[g*8 +: 8];
            if (w == 8'h00) begin
                k = ZL;
                lat = 1;
            end else begin
                k = 0;
                while (w[k] == 1'b0) k++;
                lat = k + 2;
            end
            do_txn($sformatf("rnd%0d", r), v, d, $urandom_range(0, 3), g, k,
                   (w == 8'h00) ? 8'h00 : 8'(w >> k), lat);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
